// File: rtl/encoder_pkg.sv
// Shared types for the encoder_rr block: run-time mode encoding.
// No logic, no latency.
// No flow control.
package encoder_pkg;

  // Run-time encode mode, sampled together with each accepted request vector.
  typedef enum logic [1:0] {
    MODE_STRICT = 2'd0,
    MODE_PRI_LO = 2'd1,
    MODE_PRI_HI = 2'd2,
    MODE_RR     = 2'd3
  } mode_e;

endpackage

// File: rtl/encoder_rr_pri_find.sv
// First-set-bit finder: searches vec upward from start, wrapping at N-1.
// Purely combinational, zero latency.
// No flow control; idx is 0 when found is low.
module pri_find #(
  parameter  int N     = 16,
  localparam int OUT_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [OUT_W-1:0] start,
  output logic [OUT_W-1:0] idx,
  output logic             found
);

  // Walk N positions starting at start; the first set bit wins.
  always_comb begin
    int               j;
    logic [OUT_W-1:0] jj;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      jj = j[OUT_W-1:0];
      if (!found && vec[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/encoder_rr.sv
// Registered N-to-log2(N) encoder: strict one-hot, low/high priority, round-robin.
// One cycle: vector accepted at edge t is presented with out_valid from t+1.
// Single-entry stage; in_ready = !out_valid || out_ready, outputs and ptr hold while stalled.
module encoder_rr
  import encoder_pkg::*;
#(
  parameter  int N     = 16,
  localparam int OUT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] enc_out,
  output logic             out_none,
  output logic             out_err
);

  mode_e            mode_sel;
  logic             accept;
  logic [N-1:0]     rev_vec;
  logic [OUT_W-1:0] fwd_start;
  logic [OUT_W-1:0] fwd_idx;
  logic             fwd_found;
  logic [OUT_W-1:0] rev_idx;
  logic             rev_found;
  logic [OUT_W-1:0] hi_idx;
  logic             multi;

  logic [OUT_W-1:0] ptr_q, ptr_d;
  logic [OUT_W-1:0] enc_q, enc_d;
  logic             none_q, none_d;
  logic             err_q, err_d;
  logic             out_valid_q;

  assign mode_sel = mode_e'(mode);

  // Slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Bit-reverse so that a forward search from 0 finds the highest set bit.
  always_comb begin
    rev_vec = '0;
    for (int i = 0; i < N; i++) rev_vec[i] = in_vec[N-1-i];
  end

  // Forward search serves STRICT/PRI_LO (from 0) and RR (from ptr).
  assign fwd_start = (mode_sel == MODE_RR) ? ptr_q : '0;

  pri_find #(.N(N)) u_fwd (
    .vec   (in_vec),
    .start (fwd_start),
    .idx   (fwd_idx),
    .found (fwd_found)
  );

  pri_find #(.N(N)) u_rev (
    .vec   (rev_vec),
    .start ('0),
    .idx   (rev_idx),
    .found (rev_found)
  );

  assign hi_idx = OUT_W'(N - 1) - rev_idx;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi = |(in_vec & (in_vec - N'(1)));

  // Next result and next round-robin pointer for the beat on the inputs.
  always_comb begin
    enc_d  = '0;
    none_d = !fwd_found;
    err_d  = 1'b0;
    ptr_d  = ptr_q;
    case (mode_sel)
      MODE_STRICT: begin
        if (multi) err_d = 1'b1;
        else       enc_d = fwd_idx;
      end
      MODE_PRI_LO: enc_d = fwd_idx;
      MODE_PRI_HI: begin
        if (rev_found) enc_d = hi_idx;
      end
      MODE_RR: begin
        enc_d = fwd_idx;
        if (fwd_found) begin
          ptr_d = (fwd_idx == OUT_W'(N - 1)) ? '0 : fwd_idx + OUT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output register and pointer: load on accept, drop valid on drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      enc_q       <= '0;
      none_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      enc_q       <= enc_d;
      none_q      <= none_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign enc_out   = enc_q;
  assign out_none  = none_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_encoder_rr.sv
module tb_encoder_rr;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N = 16 instance
  logic        in_valid, in_ready, out_valid, out_ready, out_none, out_err;
  logic [15:0] in_vec;
  logic [1:0]  mode;
  logic [3:0]  enc_out;

  // N = 5 instance
  logic        in_valid5, in_ready5, out_valid5, out_ready5, out_none5, out_err5;
  logic [4:0]  in_vec5;
  logic [1:0]  mode5;
  logic [2:0]  enc_out5;

  encoder_rr #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .enc_out(enc_out), .out_none(out_none), .out_err(out_err)
  );

  encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_vec(in_vec5), .mode(mode5), .out_valid(out_valid5), .out_ready(out_ready5),
    .enc_out(enc_out5), .out_none(out_none5), .out_err(out_err5)
  );

  typedef struct {
    logic [15:0] vec;
    logic [1:0]  mode;
    logic [3:0]  enc;
    logic        none;
    logic        err;
    logic [3:0]  ptr;
  } vec_t;

  typedef struct {
    logic [3:0] enc;
    logic       none;
    logic       err;
    logic [3:0] ptr;
  } exp_t;

  exp_t q16[$];
  exp_t q5[$];
  exp_t nxt16, nxt5;
  vec_t tab[30];
  vec_t tab5[6];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] v, input logic [1:0] m, input logic [3:0] e,
                              input logic n, input logic er, input logic [3:0] p);
    vec_t r;
    r.vec = v; r.mode = m; r.enc = e; r.none = n; r.err = er; r.ptr = p;
    return r;
  endfunction

  function automatic exp_t ex(input vec_t t);
    exp_t r;
    r.enc = t.enc; r.none = t.none; r.err = t.err; r.ptr = t.ptr;
    return r;
  endfunction

  // Runs at the falling edge: compare outputs being consumed, then record accepted beats.
  task automatic monitor();
    exp_t e;
    if (out_valid && out_ready) begin
      if (q16.size() == 0) check("n16 unexpected output", 1, 0);
      else begin
        e = q16.pop_front();
        check("n16 enc_out", enc_out, e.enc);
        check("n16 out_none", out_none, e.none);
        check("n16 out_err", out_err, e.err);
        check("n16 ptr", dut16.ptr_q, e.ptr);
      end
    end
    if (out_valid5) check("n5 enc range", enc_out5 <= 3'd4, 1);
    if (out_valid5 && out_ready5) begin
      if (q5.size() == 0) check("n5 unexpected output", 1, 0);
      else begin
        e = q5.pop_front();
        check("n5 enc_out", enc_out5, e.enc);
        check("n5 out_none", out_none5, e.none);
        check("n5 out_err", out_err5, e.err);
        check("n5 ptr", dut5.ptr_q, e.ptr);
      end
    end
    if (in_valid && in_ready)   q16.push_back(nxt16);
    if (in_valid5 && in_ready5) q5.push_back(nxt5);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q16.size() != 0 || q5.size() != 0); i++) tick();
    check("drain pending results", q16.size() + q5.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 16; k++) tab[k] = mk(16'h0001 << k, MODE_STRICT, 4'(k), 0, 0, 0);
    tab[16] = mk(16'h0000, MODE_STRICT, 0,  1, 0, 0);
    tab[17] = mk(16'h0003, MODE_STRICT, 0,  0, 1, 0);
    tab[18] = mk(16'h8810, MODE_STRICT, 0,  0, 1, 0);
    tab[19] = mk(16'h8810, MODE_PRI_LO, 4,  0, 0, 0);
    tab[20] = mk(16'h8810, MODE_PRI_HI, 15, 0, 0, 0);
    tab[21] = mk(16'h0001, MODE_PRI_HI, 0,  0, 0, 0);
    tab[22] = mk(16'h0000, MODE_PRI_LO, 0,  1, 0, 0);
    tab[23] = mk(16'h8810, MODE_RR,     4,  0, 0, 5);
    tab[24] = mk(16'h8810, MODE_RR,     11, 0, 0, 12);
    tab[25] = mk(16'h0000, MODE_RR,     0,  1, 0, 12);
    tab[26] = mk(16'h8810, MODE_RR,     15, 0, 0, 0);
    tab[27] = mk(16'h8810, MODE_RR,     4,  0, 0, 5);
    tab[28] = mk(16'h8810, MODE_PRI_HI, 15, 0, 0, 5);
    tab[29] = mk(16'h8810, MODE_RR,     11, 0, 0, 12);

    tab5[0] = mk(16'h0011, MODE_RR,     0, 0, 0, 1);
    tab5[1] = mk(16'h0011, MODE_RR,     4, 0, 0, 0);
    tab5[2] = mk(16'h0011, MODE_RR,     0, 0, 0, 1);
    tab5[3] = mk(16'h001F, MODE_PRI_HI, 4, 0, 0, 1);
    tab5[4] = mk(16'h0010, MODE_STRICT, 4, 0, 0, 1);
    tab5[5] = mk(16'h0003, MODE_STRICT, 0, 0, 1, 1);

    in_valid = 0; in_vec = '0; mode = MODE_STRICT; out_ready = 1;
    in_valid5 = 0; in_vec5 = '0; mode5 = MODE_STRICT; out_ready5 = 1;
    nxt16 = ex(tab[0]); nxt5 = ex(tab5[0]);

    // Reset state
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset enc_out", enc_out, 0);
    check("reset out_none", out_none, 0);
    check("reset out_err", out_err, 0);
    check("reset ptr", dut16.ptr_q, 0);
    check("reset n5 out_valid", out_valid5, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("in_ready after reset", in_ready, 1);

    // Table stream, back-to-back with out_ready = 1
    for (int i = 0; i < 30; i++) begin
      in_valid = 1; in_vec = tab[i].vec; mode = tab[i].mode; nxt16 = ex(tab[i]);
      if (i > 0) begin
        check("no bubble out_valid", out_valid, 1);
        check("no bubble in_ready", in_ready, 1);
      end
      tick();
    end
    in_valid = 0;
    drain();

    // Backpressure: one RR beat (ptr 12 -> grant 15), then 3 stalled cycles
    out_ready = 0;
    in_valid = 1; in_vec = 16'h8810; mode = MODE_RR;
    nxt16.enc = 15; nxt16.none = 0; nxt16.err = 0; nxt16.ptr = 0;
    tick();
    in_vec = 16'h0001; mode = MODE_PRI_LO;
    for (int c = 0; c < 3; c++) begin
      check("stall in_ready", in_ready, 0);
      check("stall out_valid", out_valid, 1);
      check("stall enc_out held", enc_out, 15);
      check("stall ptr held", dut16.ptr_q, 0);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    drain();

    // Reset with a pending result and ptr = 12
    in_valid = 1; in_vec = 16'h8810; mode = MODE_RR;
    nxt16.enc = 4;  nxt16.ptr = 5;
    tick();
    nxt16.enc = 11; nxt16.ptr = 12;
    tick();
    in_valid = 0; out_ready = 0;
    check("pre-reset out_valid", out_valid, 1);
    check("pre-reset ptr", dut16.ptr_q, 12);
    #2 rst_n = 0;
    #1;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset enc_out", enc_out, 0);
    check("mid reset ptr", dut16.ptr_q, 0);
    q16.delete();
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    in_valid = 1; in_vec = 16'h8810; mode = MODE_RR;
    nxt16.enc = 4; nxt16.none = 0; nxt16.err = 0; nxt16.ptr = 5;
    tick();
    in_valid = 0;
    drain();

    // Non-power-of-two instance
    for (int i = 0; i < 6; i++) begin
      in_valid5 = 1; in_vec5 = tab5[i].vec[4:0]; mode5 = tab5[i].mode; nxt5 = ex(tab5[i]);
      tick();
    end
    in_valid5 = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
